// File: rtl/seq_alu_bank.sv
// seq_alu_bank: sequenced ALU register bank.
// One accepted transaction walks IDLE -> ADD -> LOGIC -> DONE -> IDLE.
// Along the way it fills the sum, difference, AND and OR registers, then
// folds the difference into the accumulator c.
module seq_alu_bank #(
  parameter int WIDTH    = 8,
  parameter int CLR_PLUS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sat_en,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] plus_reg,
  output logic [WIDTH-1:0] mins_reg,
  output logic [WIDTH-1:0] bw_and_reg,
  output logic [WIDTH-1:0] bw_or_reg,
  output logic             carry,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, ADD, LOGIC, DONE} state_t;

  state_t           state, nxt;
  logic             sat;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             lt;

  // Arithmetic on the latched operands; the extra sum bit is the carry.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;
  assign lt   = (a < b);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state: fixed sequence, only IDLE waits (for start_valid).
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_valid) nxt = ADD;
      ADD:     nxt = LOGIC;
      LOGIC:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Status outputs are decoded directly from the state.
  always_comb begin
    start_ready = (state == IDLE);
    busy        = (state != IDLE);
    done        = (state == DONE);
  end

  // Datapath. Each state writes only its own registers.
  // acc_clr overrides the DONE accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      a          <= '0;
      b          <= '0;
      c          <= '0;
      sat        <= 1'b0;
      plus_reg   <= '0;
      mins_reg   <= '0;
      bw_and_reg <= '0;
      bw_or_reg  <= '0;
      carry      <= 1'b0;
      borrow     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          a   <= op_a;
          b   <= op_b;
          sat <= sat_en;
        end
        ADD: begin
          carry    <= sum[WIDTH];
          plus_reg <= (sat && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
        end
        LOGIC: begin
          borrow     <= lt;
          mins_reg   <= (sat && lt) ? '0 : diff;
          bw_and_reg <= a & b;
          bw_or_reg  <= a | b;
          if (CLR_PLUS != 0) plus_reg <= '0;
        end
        default: ;
      endcase
      if (acc_clr)              c <= '0;
      else if (state == DONE)   c <= c + mins_reg;
    end
  end

endmodule

// File: tb/tb_seq_alu_bank.sv
// Directed bench for seq_alu_bank.
// u0: WIDTH=8 with CLR_PLUS=1. u1: WIDTH=8 with CLR_PLUS=0. u2: WIDTH=16.
module tb_seq_alu_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit operands are shared by u0/u1; each instance has its own start_valid.
  logic        sv0 = 1'b0, sv1 = 1'b0, sv2 = 1'b0;
  logic [7:0]  op_a = '0, op_b = '0;
  logic        sat_en = 1'b0, acc_clr0 = 1'b0, acc_clr_x = 1'b0;
  logic [15:0] op_a2 = '0, op_b2 = '0;

  logic        rdy0, rdy1, rdy2, car0, car1, car2, bor0, bor1, bor2;
  logic        busy0, busy1, busy2, done0, done1, done2;
  logic [7:0]  a0, b0, c0, p0, m0, an0, or0;
  logic [7:0]  a1, b1, c1, p1, m1, an1, or1;
  logic [15:0] a2, b2, c2, p2, m2, an2, or2;

  seq_alu_bank #(.WIDTH(8), .CLR_PLUS(1)) u0 (
    .clk(clk), .rst(rst), .start_valid(sv0), .start_ready(rdy0),
    .op_a(op_a), .op_b(op_b), .sat_en(sat_en), .acc_clr(acc_clr0),
    .a(a0), .b(b0), .c(c0), .plus_reg(p0), .mins_reg(m0),
    .bw_and_reg(an0), .bw_or_reg(or0), .carry(car0), .borrow(bor0),
    .busy(busy0), .done(done0));

  seq_alu_bank #(.WIDTH(8), .CLR_PLUS(0)) u1 (
    .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(rdy1),
    .op_a(op_a), .op_b(op_b), .sat_en(sat_en), .acc_clr(acc_clr_x),
    .a(a1), .b(b1), .c(c1), .plus_reg(p1), .mins_reg(m1),
    .bw_and_reg(an1), .bw_or_reg(or1), .carry(car1), .borrow(bor1),
    .busy(busy1), .done(done1));

  seq_alu_bank #(.WIDTH(16), .CLR_PLUS(1)) u2 (
    .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(rdy2),
    .op_a(op_a2), .op_b(op_b2), .sat_en(1'b0), .acc_clr(acc_clr_x),
    .a(a2), .b(b2), .c(c2), .plus_reg(p2), .mins_reg(m2),
    .bw_and_reg(an2), .bw_or_reg(or2), .carry(car2), .borrow(bor2),
    .busy(busy2), .done(done2));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept on u0, then step to the edge after DONE (back in IDLE).
  task automatic run0(input logic [7:0] x, input logic [7:0] y, input logic s);
    op_a = x; op_b = y; sat_en = s; sv0 = 1'b1;
    tick(); sv0 = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready", rdy0, 1);
    chk("rst_busy",  busy0, 0);
    chk("rst_done",  done0, 0);
    chk("rst_regs",  {a0, b0, c0, p0}, 0);
    chk("rst_regs2", {m0, an0, or0, 6'b0, car0, bor0}, 0);

    // 36,12 on the CLR_PLUS=1 instance
    op_a = 8'd36; op_b = 8'd12; sat_en = 1'b0; sv0 = 1'b1;
    tick(); sv0 = 1'b0;                              // accept at T
    chk("acc_a", a0, 36); chk("acc_b", b0, 12);
    chk("acc_busy", busy0, 1); chk("acc_ready", rdy0, 0);
    tick();                                          // ADD at T+1
    chk("add_plus", p0, 48); chk("add_carry", car0, 0);
    tick();                                          // LOGIC at T+2 -> DONE
    chk("dn_done", done0, 1); chk("dn_plus", p0, 0);
    chk("dn_mins", m0, 24); chk("dn_and", an0, 4); chk("dn_or", or0, 44);
    chk("dn_borrow", bor0, 0);
    tick();                                          // T+3
    chk("c24", c0, 24); chk("post_done", done0, 0);
    tick();
    chk("hold_c", c0, 24); chk("hold_mins", m0, 24); chk("hold_ready", rdy0, 1);

    // Subtraction borrow, wrapping and saturating
    run0(8'd12, 8'd36, 1'b0);
    chk("sub_wrap", m0, 232); chk("sub_borrow", bor0, 1);
    run0(8'd12, 8'd36, 1'b1);
    chk("sub_sat", m0, 0); chk("sub_sat_borrow", bor0, 1);

    // Addition carry on the CLR_PLUS=0 instance
    op_a = 8'd200; op_b = 8'd100; sat_en = 1'b0; sv1 = 1'b1;
    tick(); sv1 = 1'b0; tick();
    chk("add_wrap", p1, 44); chk("add_wrap_carry", car1, 1);
    tick(); tick();
    chk("add_wrap_hold", p1, 44);
    op_a = 8'd200; op_b = 8'd100; sat_en = 1'b1; sv1 = 1'b1;
    tick(); sv1 = 1'b0; tick();
    chk("add_sat", p1, 255); chk("add_sat_carry", car1, 1);
    tick(); tick();
    chk("add_sat_hold", p1, 255);

    // Back-to-back with start_valid held high
    acc_clr0 = 1'b1; tick(); acc_clr0 = 1'b0;
    chk("acc_clr_idle", c0, 0);
    op_a = 8'd36; op_b = 8'd12; sat_en = 1'b0; sv0 = 1'b1;
    tick();                                          // accept at T
    op_a = 8'd50; op_b = 8'd20;
    tick();
    chk("b2b_ignore_a", a0, 36); chk("b2b_ready_lo", rdy0, 0);
    tick(); tick();                                  // T+3
    chk("b2b_c1", c0, 24); chk("b2b_a_hold", a0, 36);
    tick();                                          // second accept at T+4
    sv0 = 1'b0;
    chk("b2b_a2", a0, 50); chk("b2b_busy", busy0, 1);
    tick(); tick(); tick();
    chk("b2b_c2", c0, 54); chk("b2b_mins", m0, 30);

    // Reset asserted while the FSM is in LOGIC
    op_a = 8'd7; op_b = 8'd3; sv0 = 1'b1;
    tick(); sv0 = 1'b0; tick();                      // now in LOGIC
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_regs", {a0, b0, c0, p0}, 0);
    chk("rst_mid_regs2", {m0, an0, or0, 8'b0}, 0);
    chk("rst_mid_flags", {car0, bor0, busy0, done0}, 0);
    chk("rst_mid_ready", rdy0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_nodone", done0, 0);
      tick();
    end

    // acc_clr during DONE wins over accumulate
    run0(8'd36, 8'd12, 1'b0);
    chk("pre_clr_c", c0, 24);
    op_a = 8'd50; op_b = 8'd20; sv0 = 1'b1;
    tick(); sv0 = 1'b0; tick(); tick();
    chk("clr_in_done", done0, 1);
    acc_clr0 = 1'b1;
    tick(); acc_clr0 = 1'b0;
    chk("clr_c", c0, 0);

    // 16-bit instance
    op_a2 = 16'hFFFF; op_b2 = 16'h0001; sv2 = 1'b1;
    tick(); sv2 = 1'b0; tick();
    chk("w16_plus", p2, 16'h0000); chk("w16_carry", car2, 1);
    tick();
    chk("w16_mins", m2, 16'hFFFE); chk("w16_and", an2, 16'h0001);
    chk("w16_or", or2, 16'hFFFF); chk("w16_borrow", bor2, 0);
    tick();
    chk("w16_c", c2, 16'hFFFE);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
